kernel_window_buffer: RTL

KERNEL_WINDOW_BUFFER -- requirements
Module: kernel_window_buffer

---
 rtl/kernel_window_buffer.sv | 97 +++++++++
 1 files changed

// File: rtl/kernel_window_buffer.sv
// kernel_window_buffer: streams raster pixels through K-1 line buffers and emits one
// KxK window per accepted pixel once the first K-1 lines of a frame are primed.
module kernel_window_buffer #(
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_WIDTH   = 854,
    parameter int IMG_HEIGHT  = 480,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [DATA_WIDTH-1:0]                          s_data,
    input  logic                                           s_valid,
    output logic                                           s_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]  m_window,
    output logic                                           m_valid,
    input  logic                                           m_ready,
    output logic                                           m_border,
    output logic [$clog2(IMG_HEIGHT)-1:0]                  m_row,
    output logic [$clog2(IMG_WIDTH)-1:0]                   m_col,
    output logic                                           m_last
);
    localparam int K  = KERNEL_SIZE;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_EDGE  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_PRIME = RW'(K - 2);

    if (K < 2 || K > IMG_WIDTH || K > IMG_HEIGHT) begin : g_bad_kernel
        $error("kernel_window_buffer: KERNEL_SIZE out of range");
    end

    typedef enum logic {S_FILL, S_RUN} state_t;

    state_t                state;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DATA_WIDTH-1:0] lines [K-1][IMG_WIDTH];
    logic [DATA_WIDTH-1:0] win [K][K];
    logic                  s_fire;
    logic                  eol;
    logic                  eof;

    assign s_ready = !m_valid || m_ready;
    assign s_fire  = s_valid && s_ready;
    assign eol     = col == COL_LAST;
    assign eof     = eol && row == ROW_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FILL;
            col      <= '0;
            row      <= '0;
            m_valid  <= 1'b0;
            m_border <= 1'b0;
            m_last   <= 1'b0;
            m_row    <= '0;
            m_col    <= '0;
        end else begin
            if (m_ready) m_valid <= 1'b0;
            if (s_fire) begin
                col     <= eol ? '0 : col + 1'b1;
                row     <= eof ? '0 : eol ? row + 1'b1 : row;
                state   <= eof ? S_FILL : (eol && row == ROW_PRIME) ? S_RUN : state;
                m_valid <= state == S_RUN;
                if (state == S_RUN) begin
                    m_row    <= row;
                    m_col    <= col;
                    m_border <= col < COL_EDGE;
                    m_last   <= eof;
                end
            end
        end
    end

    // Window slides one column per pixel; the new right column is the stored column plus the fresh pixel.
    always_ff @(posedge clk) begin
        if (s_fire) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K - 1; c++)
                    win[r][c] <= win[r][c+1];
            for (int r = 0; r < K - 1; r++)
                win[r][K-1] <= lines[r][col];
            win[K-1][K-1] <= s_data;
            for (int r = 0; r < K - 2; r++)
                lines[r][col] <= lines[r+1][col];
            lines[K-2][col] <= s_data;
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_r
        for (genvar c = 0; c < K; c++) begin : g_c
            assign m_window[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
        end
    end
endmodule
